// File: rtl/fp_pipe_pkg.sv
// Shared types and helpers for the floating-point adder pipeline registers.
// Stage valid vectors are sized for the deepest supported pipe.
package fp_pipe_pkg;

  localparam int FP_W      = 32;
  localparam int MAX_DEPTH = 32;

  typedef logic [MAX_DEPTH-1:0] stage_vec_t;

  // Never returns zero, so a 1-deep pipe still gets a 1-bit counter.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int popcount(input stage_vec_t v);
    int c;
    c = 0;
    for (int i = 0; i < MAX_DEPTH; i++)
      c = c + int'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/fp_pipe_cell.sv
// One elastic pipeline stage: valid/data registers and its ready term.
// The kill input clears the valid bit but keeps the data register.
module fp_pipe_cell
  import fp_pipe_pkg::*;
#(
  parameter int WIDTH = FP_W
) (
  input  logic             Clk,
  input  logic             Clear_n,
  input  logic             kill,
  input  logic             src_v,
  input  logic [WIDTH-1:0] src_d,
  input  logic             nxt_r,
  output logic             v,
  output logic [WIDTH-1:0] d,
  output logic             r,
  output logic             v_next
);

  // An empty stage always accepts, which closes bubbles during stalls.
  assign r = ~v | nxt_r;

  always_comb begin
    v_next = v;
    if (!Clear_n || kill)
      v_next = 1'b0;
    else if (r)
      v_next = src_v;
  end

  always_ff @(posedge Clk) begin
    if (!Clear_n) begin
      v <= 1'b0;
      d <= '0;
    end else begin
      v <= v_next;
      if (!kill && r && src_v)
        d <= src_d;
    end
  end

endmodule

// File: rtl/fp_pipe_stage.sv
// Elastic DEPTH x WIDTH pipeline register with valid/ready handshake.
// Optional macro FP_PIPE_FLUSH_EN adds a flush input that drops all items.
module fp_pipe_stage
  import fp_pipe_pkg::*;
#(
  parameter int WIDTH = FP_W,
  parameter int DEPTH = 2,
  parameter int CNT_W = clog2_safe(DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             Clear_n,
`ifdef FP_PIPE_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] occupancy
);

  if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
    $error("fp_pipe_stage: DEPTH out of range");
  end

  logic kill;
`ifdef FP_PIPE_FLUSH_EN
  assign kill = flush;
`else
  assign kill = 1'b0;
`endif

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] v_next;
  logic [WIDTH-1:0] d [DEPTH];

  // Ready travels per-stage so the chain is not one looped vector.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             r_k;
    logic             nxt_r;
    logic             src_v;
    logic [WIDTH-1:0] src_d;

    if (k == 0) begin : g_head
      assign src_v = in_valid;
      assign src_d = in_data;
    end else begin : g_link
      assign src_v = v[k-1];
      assign src_d = d[k-1];
    end

    if (k == DEPTH - 1) begin : g_tail
      assign nxt_r = out_ready;
    end else begin : g_mid
      assign nxt_r = g_stage[k+1].r_k;
    end

    fp_pipe_cell #(
      .WIDTH(WIDTH)
    ) u_cell (
      .Clk    (Clk),
      .Clear_n(Clear_n),
      .kill   (kill),
      .src_v  (src_v),
      .src_d  (src_d),
      .nxt_r  (nxt_r),
      .v      (v[k]),
      .d      (d[k]),
      .r      (r_k),
      .v_next (v_next[k])
    );
  end

  assign in_ready  = g_stage[0].r_k;
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

  stage_vec_t vn_ext;
  assign vn_ext = stage_vec_t'(v_next);

  always_ff @(posedge Clk) begin
    if (!Clear_n)
      occupancy <= '0;
    else
      occupancy <= CNT_W'(popcount(vn_ext));
  end

endmodule

// File: tb/tb_fp_pipe_stage.sv
// Scoreboard bench for fp_pipe_stage: directed scenarios then random traffic.
// Build with FP_PIPE_FLUSH_EN defined to exercise the flush port.
module tb_fp_pipe_stage;
  import fp_pipe_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int CNT_W = clog2_safe(DEPTH + 1);

  logic             Clk = 1'b0;
  logic             Clear_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] occupancy;

  always #5 Clk = ~Clk;

  fp_pipe_stage #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .Clk      (Clk),
    .Clear_n  (Clear_n),
`ifdef FP_PIPE_FLUSH_EN
    .flush    (flush),
`endif
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .occupancy(occupancy)
  );

  typedef struct {
    logic [WIDTH-1:0] data;
    int               cyc;
  } item_t;

  item_t exp_q[$];

  int n_vec     = 0;
  int n_err     = 0;
  int cyc       = 0;
  int last_low  = 0;
  int model_cnt = 0;
  bit armed     = 0;
  bit in_x      = 0;
  bit prev_clr  = 0;
  bit prev_kill = 0;
  bit prev_hold = 0;
  logic [WIDTH-1:0] prev_data = '0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Drive one cycle at the falling edge; log accepted inputs.
  task automatic step(input bit clr, input bit fl, input bit iv,
                      input logic [WIDTH-1:0] id, input bit ordy);
    @(negedge Clk);
    Clear_n   = clr;
    flush     = fl;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    #1;
    in_x = clr && !fl && iv && in_ready;
    if (in_x) exp_q.push_back('{id, cyc});
  endtask

  // Monitor: the item count model is a plain FIFO of accepted words.
  initial begin
    item_t it;
    bit    ox;
    forever begin
      @(negedge Clk);
      #2;
      ox = 1'b0;
      if (armed) begin
        chk("occupancy", 64'(occupancy), 64'(model_cnt));
        chk("in_ready", 64'(in_ready),
            64'((model_cnt < DEPTH) || out_ready));
        if (prev_clr) begin
          chk("valid_after_clear", 64'(out_valid), 64'(0));
          chk("data_after_clear", 64'(out_data), 64'(0));
        end else if (prev_kill) begin
          chk("valid_after_flush", 64'(out_valid), 64'(0));
          chk("data_after_flush", 64'(out_data), 64'(prev_data));
        end else if (prev_hold) begin
          chk("stall_valid", 64'(out_valid), 64'(1));
          chk("stall_data", 64'(out_data), 64'(prev_data));
        end
        if (Clear_n && out_valid && out_ready) begin
          ox = 1'b1;
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_output: got %0h expected none",
                     out_data);
          end else begin
            it = exp_q.pop_front();
            chk("out_data", 64'(out_data), 64'(it.data));
            if (it.cyc > last_low)
              chk("latency", 64'(cyc - it.cyc), 64'(DEPTH));
          end
        end
      end
      #1;
      prev_clr  = !Clear_n;
      prev_kill = Clear_n && flush;
      prev_hold = Clear_n && !flush && out_valid && !out_ready;
      prev_data = out_data;
      if (!Clear_n) armed = 1'b1;
      if (!Clear_n || flush) begin
        model_cnt = 0;
        exp_q.delete();
      end else begin
        model_cnt = model_cnt + int'(in_x) - int'(ox);
      end
      if (!out_ready) last_low = cyc;
      cyc++;
    end
  end

  initial begin
    int guard;
    bit clr, fl, iv, ordy;
    Clear_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    step(0, 0, 1, 32'hDEAD_BEEF, 1);
    step(0, 0, 1, 32'hDEAD_BEEF, 1);
    step(1, 0, 0, 0, 1);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_out_data", 64'(out_data), 64'(0));
    chk("reset_occupancy", 64'(occupancy), 64'(0));
    chk("reset_in_ready", 64'(in_ready), 64'(1));
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);

    step(1, 0, 1, 1, 1);
    step(1, 0, 1, 2, 1);
    step(1, 0, 1, 3, 1);
    #1;
    chk("stream_occupancy", 64'(occupancy), 64'(2));
    chk("stream_first_out", 64'(out_data), 64'(1));
    repeat (3) step(1, 0, 0, 0, 1);

    step(1, 0, 1, 32'hA, 0);
    step(1, 0, 1, 32'hB, 0);
    step(1, 0, 0, 0, 0);
    #1;
    chk("bp_in_ready", 64'(in_ready), 64'(0));
    chk("bp_occupancy", 64'(occupancy), 64'(2));
    chk("bp_out_data", 64'(out_data), 64'(32'hA));
    step(1, 0, 1, 32'hC, 0);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);

    step(1, 0, 1, 5, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 6, 0);
    #1;
    chk("bubble_in_ready", 64'(in_ready), 64'(1));
    step(1, 0, 0, 0, 0);
    #1;
    chk("bubble_occupancy", 64'(occupancy), 64'(2));
    chk("bubble_full_ready", 64'(in_ready), 64'(0));
    repeat (3) step(1, 0, 0, 0, 1);

    step(1, 0, 1, 7, 0);
    step(1, 0, 1, 8, 0);
    step(1, 0, 1, 9, 1);
    #1;
    chk("pushpop_in_ready", 64'(in_ready), 64'(1));
    chk("pushpop_out", 64'(out_data), 64'(7));
    step(1, 0, 0, 0, 1);
    #1;
    chk("pushpop_occupancy", 64'(occupancy), 64'(2));
    chk("pushpop_next", 64'(out_data), 64'(8));
    repeat (3) step(1, 0, 0, 0, 1);

    step(1, 0, 1, 32'h11, 0);
    step(1, 0, 1, 32'h12, 0);
    step(0, 0, 1, 32'h13, 0);
    step(1, 0, 0, 0, 0);
    #1;
    chk("midreset_valid", 64'(out_valid), 64'(0));
    chk("midreset_occupancy", 64'(occupancy), 64'(0));

`ifdef FP_PIPE_FLUSH_EN
    step(1, 0, 1, 32'h21, 0);
    step(1, 0, 1, 32'h22, 0);
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    #1;
    chk("flush_occupancy", 64'(occupancy), 64'(0));
    chk("flush_valid", 64'(out_valid), 64'(0));
    chk("flush_data", 64'(out_data), 64'(32'h21));
`endif

    for (int i = 0; i < 3000; i++) begin
      clr = ($urandom_range(0, 99) != 0);
`ifdef FP_PIPE_FLUSH_EN
      fl = ($urandom_range(0, 49) == 0);
`else
      fl = 1'b0;
`endif
      iv = ($urandom_range(0, 9) < 7);
      if (((i / 200) % 2) == 1)
        ordy = 1'b1;
      else
        ordy = ($urandom_range(0, 9) < 6);
      step(clr, fl, iv, $urandom, ordy);
    end

    guard = 0;
    while (exp_q.size() != 0 && guard < 4 * DEPTH + 10) begin
      step(1, 0, 0, 0, 1);
      guard++;
    end
    step(1, 0, 0, 0, 1);
    #2;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d items stuck expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
